// File: rtl/dcache_pkg.sv
// Shared types and defaults for the N-way data-cache storage array.
// Flush FSM encodings are used only when DCACHE_FLUSH_EN is defined.
package dcache_pkg;

  localparam int DC_WAYS   = 4;
  localparam int DC_SETS   = 16;
  localparam int DC_TAG_W  = 23;
  localparam int DC_LINE_W = 256;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_WRITE  = 2'b01,
    OP_FILL   = 2'b10,
    OP_RSVD   = 2'b11
  } dcache_op_e;

  typedef logic [1:0] flush_state_t;
  localparam flush_state_t FL_IDLE = 2'd0;
  localparam flush_state_t FL_SCAN = 2'd1;
  localparam flush_state_t FL_EMIT = 2'd2;
  localparam flush_state_t FL_DONE = 2'd3;

endpackage

// File: rtl/dcache_lru.sv
// True-LRU age update and victim select for one set.
// Age 0 is MRU; the ages of a set always form a permutation of 0..WAYS-1.
module dcache_lru #(
  parameter int WAYS = 4,
  parameter int AW   = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AW-1:0] age_i,
  input  logic [WAYS-1:0]         valid_i,
  input  logic [AW-1:0]           promote_way_i,
  output logic [WAYS-1:0][AW-1:0] age_o,
  output logic [AW-1:0]           victim_way_o
);

  logic [AW-1:0] pivot;
  logic          found_inv;

  assign pivot = age_i[promote_way_i];

  // Promoted way becomes MRU; only ways younger than it age by one.
  always_comb begin
    age_o = age_i;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == promote_way_i) begin
        age_o[w] = '0;
      end else if (age_i[w] < pivot) begin
        age_o[w] = age_i[w] + AW'(1);
      end
    end
  end

  always_comb begin
    victim_way_o = '0;
    found_inv    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_i[w]) begin
        victim_way_o = AW'(w);
        found_inv    = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_i[w] == AW'(WAYS - 1)) victim_way_o = AW'(w);
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache array with true-LRU, dirty tracking and victim reporting.
// Optional flush engine enabled by defining DCACHE_FLUSH_EN.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int WAYS   = DC_WAYS,
  parameter int SETS   = DC_SETS,
  parameter int TAG_W  = DC_TAG_W,
  parameter int LINE_W = DC_LINE_W,
  parameter int AW     = $clog2(WAYS),
  parameter int SW     = $clog2(SETS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Handshake: a request is taken in any cycle where req_i && ready_o.
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [SW-1:0]     addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              dirty_i,
  output logic              ready_o,
  output logic              rsp_valid_o,
  output logic              hit_o,
  output logic [AW-1:0]     hit_way_o,
  output logic [LINE_W-1:0] data_o,
  output logic              victim_valid_o,
  output logic              victim_dirty_o,
  output logic [TAG_W-1:0]  victim_tag_o,
  output logic [LINE_W-1:0] victim_data_o
`ifdef DCACHE_FLUSH_EN
  ,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [SW-1:0]     wb_set_o,
  output logic [LINE_W-1:0] wb_data_o,
  output flush_state_t      flush_state_o
`endif
);

  logic [WAYS-1:0]         valid_q [SETS];
  logic [WAYS-1:0]         dirty_q [SETS];
  logic [WAYS-1:0][AW-1:0] age_q   [SETS];
  logic [TAG_W-1:0]        tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]       line_q  [SETS][WAYS];

  logic              rsp_valid_q, hit_q, vic_valid_q, vic_dirty_q;
  logic [AW-1:0]     hit_way_q;
  logic [LINE_W-1:0] data_q, vic_data_q;
  logic [TAG_W-1:0]  vic_tag_q;

  dcache_op_e              op;
  logic                    accept, is_fill, is_write, hit, promote, line_we;
  logic [WAYS-1:0]         hit_vec;
  logic [AW-1:0]           hit_way, victim_way, wr_way;
  logic [WAYS-1:0][AW-1:0] age_next;
  logic                    fl_clr;
  logic [SW-1:0]           fl_set;
  logic [AW-1:0]           fl_way;

  assign op       = dcache_op_e'(op_i);
  assign accept   = req_i && ready_o;
  assign is_fill  = (op == OP_FILL);
  assign is_write = (op == OP_WRITE);

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i);
      if (hit_vec[w]) hit_way = hit_way | AW'(w);
    end
  end

  assign hit     = |hit_vec;
  assign wr_way  = hit ? hit_way : victim_way;
  assign promote = accept && (hit || is_fill);
  assign line_we = accept && (is_fill || (is_write && hit));

  dcache_lru #(
    .WAYS (WAYS),
    .AW   (AW)
  ) u_lru (
    .age_i         (age_q[addr_i]),
    .valid_i       (valid_q[addr_i]),
    .promote_way_i (wr_way),
    .age_o         (age_next),
    .victim_way_o  (victim_way)
  );

  // Tag and line payloads are never reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (line_we) line_q[addr_i][wr_way] <= data_i;
    if (accept && is_fill) tag_q[addr_i][wr_way] <= tag_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end
    end else begin
      if (accept && is_fill) begin
        valid_q[addr_i][wr_way] <= 1'b1;
        dirty_q[addr_i][wr_way] <= dirty_i;
      end else if (accept && is_write && hit) begin
        dirty_q[addr_i][wr_way] <= 1'b1;
      end
      if (promote) age_q[addr_i] <= age_next;
      if (fl_clr) dirty_q[fl_set][fl_way] <= 1'b0;
    end
  end

  // Response captures pre-update contents; victim fields only describe misses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      data_q      <= '0;
      vic_valid_q <= 1'b0;
      vic_dirty_q <= 1'b0;
      vic_tag_q   <= '0;
      vic_data_q  <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        hit_q       <= hit;
        hit_way_q   <= hit ? hit_way : '0;
        data_q      <= hit ? line_q[addr_i][hit_way] : '0;
        vic_valid_q <= !hit && valid_q[addr_i][victim_way];
        vic_dirty_q <= !hit && dirty_q[addr_i][victim_way];
        vic_tag_q   <= hit ? '0 : tag_q[addr_i][victim_way];
        vic_data_q  <= hit ? '0 : line_q[addr_i][victim_way];
      end
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign hit_o          = hit_q;
  assign hit_way_o      = hit_way_q;
  assign data_o         = data_q;
  assign victim_valid_o = vic_valid_q;
  assign victim_dirty_o = vic_dirty_q;
  assign victim_tag_o   = vic_tag_q;
  assign victim_data_o  = vic_data_q;

`ifdef DCACHE_FLUSH_EN
  flush_state_t        fl_state_q, fl_state_d;
  logic [SW+AW-1:0]    fl_idx_q, fl_idx_d;
  logic                fl_last;

  assign fl_set  = fl_idx_q[SW+AW-1:AW];
  assign fl_way  = fl_idx_q[AW-1:0];
  assign fl_last = &fl_idx_q;
  assign fl_clr  = (fl_state_q == FL_EMIT) && wb_ready_i;

  always_comb begin
    fl_state_d = fl_state_q;
    fl_idx_d   = fl_idx_q;
    case (fl_state_q)
      FL_IDLE: begin
        if (flush_i && !accept) begin
          fl_state_d = FL_SCAN;
          fl_idx_d   = '0;
        end
      end
      FL_SCAN: begin
        if (valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way]) begin
          fl_state_d = FL_EMIT;
        end else if (fl_last) begin
          fl_state_d = FL_DONE;
        end else begin
          fl_idx_d = fl_idx_q + 1'b1;
        end
      end
      FL_EMIT: begin
        if (wb_ready_i) begin
          if (fl_last) begin
            fl_state_d = FL_DONE;
          end else begin
            fl_state_d = FL_SCAN;
            fl_idx_d   = fl_idx_q + 1'b1;
          end
        end
      end
      default: fl_state_d = FL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fl_state_q <= FL_IDLE;
      fl_idx_q   <= '0;
    end else begin
      fl_state_q <= fl_state_d;
      fl_idx_q   <= fl_idx_d;
    end
  end

  assign ready_o       = (fl_state_q == FL_IDLE);
  assign flush_done_o  = (fl_state_q == FL_DONE);
  assign wb_valid_o    = (fl_state_q == FL_EMIT);
  assign wb_tag_o      = tag_q[fl_set][fl_way];
  assign wb_set_o      = fl_set;
  assign wb_data_o     = line_q[fl_set][fl_way];
  assign flush_state_o = fl_state_q;
`else
  assign ready_o = 1'b1;
  assign fl_clr  = 1'b0;
  assign fl_set  = '0;
  assign fl_way  = '0;
`endif

  a_single_hit : assert property (@(posedge clk_i) disable iff (rst_i) accept |-> $onehot0(hit_vec));

endmodule
